// File: rtl/adder_window_acc_pkg.sv
// Shared defaults, window state encoding and a clog2 helper for the adder window accumulator.
package adder_window_acc_pkg;

  localparam int ADW_DATA_W     = 8;
  localparam int ADW_WIN_LEN    = 4;
  localparam int ADW_FIFO_DEPTH = 4;

  typedef enum logic {
    WIN_IDLE = 1'b0,
    WIN_FILL = 1'b1
  } win_state_e;

  function automatic int adw_clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_window_acc_result_fifo.sv
// Synchronous result FIFO; pointers carry one extra wrap bit to tell full from empty.
module adw_result_fifo
  import adder_window_acc_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = adw_clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         wr_en;
  logic         rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // The caller only pushes when full if it pops in the same cycle.
  assign wr_en = push_i && !flush_i;
  assign rd_en = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + (AW+1)'(1);
      if (rd_en) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/adder_window_acc.sv
// Accumulates WIN_LEN valid adder samples per window and queues totals in a result FIFO.
// Define ADW_ACC_SAT_EN to clamp sums at 2^ACC_W-1 instead of wrapping.
module adder_window_acc
  import adder_window_acc_pkg::*;
#(
  parameter int DATA_W     = ADW_DATA_W,
  parameter int WIN_LEN    = ADW_WIN_LEN,
  parameter int ACC_W      = ADW_DATA_W + adw_clog2(ADW_WIN_LEN),
  parameter int FIFO_DEPTH = ADW_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              ovf_err
);

  localparam int CNT_W = adw_clog2(WIN_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  win_state_e       win_state, win_state_d;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_res;
  logic             last_sample;
  logic             fifo_full, fifo_empty;
  logic             push, push_req, pop;

  assign sum_ext = {1'b0, acc_q} + {{(ACC_W+1-DATA_W){1'b0}}, in_data};
`ifdef ADW_ACC_SAT_EN
  assign sum_res = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
  assign sum_res = sum_ext[ACC_W-1:0];
`endif

  assign win_state   = (cnt_q == '0) ? WIN_IDLE : WIN_FILL;
  assign last_sample = (cnt_q == CNT_W'(WIN_LEN-1));
  assign out_valid   = !fifo_empty;

  // Pop is qualified by a valid head, so a same-cycle push into an empty FIFO never pops.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    win_state_d = win_state;
    push_req    = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    if (clr) begin
      cnt_d       = '0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      win_state_d = WIN_IDLE;
    end else begin
      pop = out_valid && out_ready;
      if (in_valid) begin
        if (last_sample) begin
          push_req    = 1'b1;
          cnt_d       = '0;
          acc_d       = '0;
          win_state_d = WIN_IDLE;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          acc_d       = sum_res;
          win_state_d = WIN_FILL;
        end
      end
      push = push_req && (!fifo_full || pop);
      if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;

  adw_result_fifo #(
    .W     (ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (sum_res),
    .pop_i   (pop),
    .flush_i (clr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (out_sum)
  );

  logic unused_state;
  assign unused_state = ^win_state_d;

endmodule

// File: tb/tb_adder_window_acc.sv
// Directed bench for adder_window_acc: default instance plus an ACC_W=8 instance for overflow handling.
module tb_adder_window_acc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       clr;
  logic       out_ready;

  logic       out_valid0;
  logic [9:0] out_sum0;
  logic       ovf0;
  logic       out_valid1;
  logic [7:0] out_sum1;
  logic       ovf1;

  int tests_run;
  int tests_failed;

  adder_window_acc u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr       (clr),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_sum   (out_sum0),
    .ovf_err   (ovf0)
  );

  adder_window_acc #(.ACC_W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr       (clr),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_sum   (out_sum1),
    .ovf_err   (ovf1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  logic [31:0] exp_sat;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clr       = 1'b0;
    out_ready = 1'b0;
`ifdef ADW_ACC_SAT_EN
    exp_sat = 32'd255;
`else
    exp_sat = 32'd144;
`endif

    tick();
    tick();
    check("reset_valid", 32'(out_valid0), 32'd0);
    check("reset_sum",   32'(out_sum0),   32'd0);
    check("reset_ovf",   32'(ovf0),       32'd0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back window, then a window of maxima with gaps
    out_ready = 1'b1;
    sample(8'd10);
    sample(8'd20);
    sample(8'd30);
    check("t1_no_early_valid", 32'(out_valid0), 32'd0);
    sample(8'd40);
    check("t1_valid", 32'(out_valid0), 32'd1);
    check("t1_sum",   32'(out_sum0),   32'd100);
    tick();
    check("t1_popped", 32'(out_valid0), 32'd0);
    check("t1_empty_sum", 32'(out_sum0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      sample(8'd255);
    end
    check("t1_max_valid", 32'(out_valid0), 32'd1);
    check("t1_max_sum",   32'(out_sum0),   32'd1020);
    tick();
    check("t1_max_popped", 32'(out_valid0), 32'd0);

    // 2: fill FIFO with out_ready low, fifth window overflows
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sample(8'd1);
    check("t2_full_no_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 4; i++) sample(8'd1);
    check("t2_ovf", 32'(ovf0), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_valid", 32'(out_valid0), 32'd1);
      check("t2_pop_sum",   32'(out_sum0),   32'd4);
      tick();
    end
    check("t2_drained", 32'(out_valid0), 32'd0);
    check("t2_ovf_sticky", 32'(ovf0), 32'd1);

    // 3: full FIFO, pop and push in the same cycle
    do_clr();
    check("t3_clr_ovf", 32'(ovf0), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sample(8'd2);
    for (int i = 0; i < 3; i++) sample(8'd3);
    out_ready = 1'b1;
    sample(8'd3);
    out_ready = 1'b0;
    check("t3_no_ovf", 32'(ovf0), 32'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t3_old_sum", 32'(out_sum0), 32'd8);
      tick();
    end
    check("t3_new_valid", 32'(out_valid0), 32'd1);
    check("t3_new_sum",   32'(out_sum0),   32'd12);
    tick();
    check("t3_drained", 32'(out_valid0), 32'd0);

    // 4: clr mid-window with in_valid high, then reset mid-window
    sample(8'd7);
    sample(8'd7);
    in_valid = 1'b1;
    in_data  = 8'd7;
    do_clr();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) sample(8'd5);
    check("t4_clr_sum", 32'(out_sum0), 32'd20);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(8'd1);
    sample(8'd7);
    sample(8'd7);
    check("t4_pre_rst_valid", 32'(out_valid0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 32'(out_valid0), 32'd0);
    check("t4_rst_sum",   32'(out_sum0),   32'd0);
    check("t4_rst_ovf",   32'(ovf0),       32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) sample(8'd5);
    check("t4_rst_win_sum", 32'(out_sum0), 32'd20);
    tick();

    // 5: narrow accumulator overflow handling
    do_clr();
    for (int i = 0; i < 4; i++) sample(8'd100);
    check("t5_wide_sum",   32'(out_sum0),   32'd400);
    check("t5_narrow_vld", 32'(out_valid1), 32'd1);
    check("t5_narrow_sum", 32'(out_sum1),   exp_sat);
    check("t5_narrow_ovf", 32'(ovf1),       32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
